// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, 1-cycle ROM pairing, 2-entry decode queue, redirect and fault handling.
// Optional build macro FETCH_PERF_EN adds handshake and stall performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0100_0000,
    parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
    parameter int unsigned IMEM_WORDS = 501
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned QDEPTH     = 2;
    localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fault_pc;
    logic [31:0] w_fault_pc_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight;
    logic [1:0]  r_count;
    logic [31:0] r_q_pc    [QDEPTH];
    logic [31:0] r_q_instr [QDEPTH];

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_credit;
    logic [2:0]  w_occ;
    logic [1:0]  w_slot;

    function automatic logic f_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && ({1'b0, pc} >= {1'b0, IMEM_BASE}) && ({1'b0, pc} < IMEM_LIMIT);
    endfunction

    assign imem_addr   = r_fetch_pc;
    assign out_valid   = (r_count != 2'd0);
    assign out_pc      = r_q_pc[0];
    assign out_instr   = r_q_instr[0];
    assign fetch_fault = (r_state == ST_FAULT);
    assign fault_pc    = r_fault_pc;

    assign w_pop    = out_valid & out_ready;
    assign w_push   = r_inflight & ~redirect_valid;
    // Queue slots plus the in-flight read may never exceed the queue depth.
    assign w_occ    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_credit = (w_occ <= 3'd1);
    assign w_slot   = r_count - 2'(w_pop);

    // Next-state: redirect dominates, then sequential issue or overrun.
    always_comb begin
        w_state_nxt    = r_state;
        w_fault_pc_nxt = r_fault_pc;
        w_issue        = 1'b0;
        if (redirect_valid) begin
            if (f_legal(redirect_pc)) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt    = ST_FAULT;
                w_fault_pc_nxt = redirect_pc;
            end
        end else if ((r_state == ST_RUN) && w_credit) begin
            if (f_legal(r_fetch_pc)) begin
                w_issue = 1'b1;
            end else begin
                w_state_nxt    = ST_FAULT;
                w_fault_pc_nxt = r_fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fault_pc <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_fault_pc <= w_fault_pc_nxt;
        end
    end

    // PC, in-flight tracking and queue; a redirect flushes everything but a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
            r_count       <= 2'd0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]    <= 32'd0;
                r_q_instr[i] <= 32'd0;
            end
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_count    <= 2'd0;
            end else begin
                if (w_pop) begin
                    r_q_pc[0]    <= r_q_pc[1];
                    r_q_instr[0] <= r_q_instr[1];
                end
                if (w_push) begin
                    if (w_slot == 2'd0) begin
                        r_q_pc[0]    <= r_inflight_pc;
                        r_q_instr[0] <= imem_data;
                    end else begin
                        r_q_pc[1]    <= r_inflight_pc;
                        r_q_instr[1] <= imem_data;
                    end
                end
                r_count <= r_count + 2'(w_push) - 2'(w_pop);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`else
    // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural 1-cycle ROM.
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;
    logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return 32'hA500_0000 | idx;
    endfunction

    // ROM: synchronous read every clock, word index relative to BASE.
    logic [31:0] rom_idx;
    assign rom_idx = (imem_addr >> 2) - 32'h0040_0000;
    always @(posedge clk) begin
        imem_data <= (rom_idx < 32'd501) ? rom_word(rom_idx) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, rom_word((pc - BASE) >> 2));
    endtask

    task automatic reset_release();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_addr", imem_addr, BASE);

        // Latency and back-to-back delivery
        rst_n = 1'b1;
        tick();
        check("lat_edge1_valid", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_head("stream", BASE + 32'(4 * i));
            tick();
        end

        // Stall 10 cycles on the first instruction, then drain without gaps
        reset_release();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_head("stall_hold", BASE);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("stall_drain", BASE + 32'(4 * i));
            tick();
        end

        // Redirect with full queue and a same-cycle handshake
        out_ready = 1'b0;
        tick();
        tick();
        check_head("full_head", BASE + 32'h10);
        out_ready = 1'b1;
        do_redirect(BASE + 32'h40);
        check("redir_r0_valid", 32'(out_valid), 32'd0);
        tick();
        check("redir_r1_valid", 32'(out_valid), 32'd0);
        tick();
        check_head("redir_first", BASE + 32'h40);
        check("redir_fault", 32'(fetch_fault), 32'd0);
        tick();
        check_head("redir_second", BASE + 32'h44);

        // Misaligned redirect faults; illegal redirect in fault updates fault_pc; legal one recovers
        do_redirect(BASE + 32'h42);
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_fault_pc", fault_pc, BASE + 32'h42);
        check("mis_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        check("mis_no_issue", 32'(out_valid), 32'd0);
        do_redirect(32'h00FF_FFFC);
        check("low_fault", 32'(fetch_fault), 32'd1);
        check("low_fault_pc", fault_pc, 32'h00FF_FFFC);
        do_redirect(BASE + 32'h08);
        check("recover_fault", 32'(fetch_fault), 32'd0);
        tick();
        check("recover_r1_valid", 32'(out_valid), 32'd0);
        tick();
        check_head("recover_first", BASE + 32'h08);

        // Sequential overrun at the top of the ROM, with queued entries draining in fault
        out_ready = 1'b0;
        do_redirect(32'h0100_07CC);
        tick();
        tick();
        tick();
        check_head("ovr_head", 32'h0100_07CC);
        check("ovr_pre_fault", 32'(fetch_fault), 32'd0);
        out_ready = 1'b1;
        tick();
        check("ovr_fault", 32'(fetch_fault), 32'd1);
        check("ovr_fault_pc", fault_pc, 32'h0100_07D4);
        check_head("ovr_last", 32'h0100_07D0);
        tick();
        check("ovr_drained", 32'(out_valid), 32'd0);
        tick();
        check("ovr_no_issue", 32'(out_valid), 32'd0);
        check("ovr_fault_hold", 32'(fetch_fault), 32'd1);

        // Reset mid-stream drops the pending response
        do_redirect(BASE + 32'h100);
        tick();
        tick();
        tick();
        check_head("mid_stream", BASE + 32'h104);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pc", out_pc, 32'd0);
        check("mid_rst_instr", out_instr, 32'd0);
        check("mid_rst_fault_pc", fault_pc, 32'd0);
        check("mid_rst_addr", imem_addr, BASE);
        rst_n = 1'b1;
        tick();
        check("mid_rel_e1_valid", 32'(out_valid), 32'd0);
        tick();
        check_head("mid_rel_first", BASE);

`ifdef FETCH_PERF_EN
        // 3 stall cycles then 5 accepted instructions
        rst_n     = 1'b0;
        out_ready = 1'b0;
        tick();
        check("perf_rst_fetched", perf_fetched, 32'd0);
        check("perf_rst_stall", perf_stall, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("perf_stall3", perf_stall, 32'd3);
        check("perf_fetched0", perf_fetched, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check("perf_fetched5", perf_fetched, 32'd5);
        check("perf_stall_hold", perf_stall, 32'd3);
        check_head("perf_head", BASE + 32'h14);
        rst_n = 1'b0;
        tick();
        check("perf_mid_fetched", perf_fetched, 32'd0);
        check("perf_mid_stall", perf_stall, 32'd0);
        check("perf_mid_valid", 32'(out_valid), 32'd0);
        check("perf_mid_pc", out_pc, 32'd0);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
